// File: rtl/sram_ro_arbiter.sv
// sram_ro_arbiter: shares the read-only port (port 1) of the 32x512 SRAM
// macro between the management RO path (A, lower half) and the
// housekeeping/flash-boot RO path (B, upper half). One read is in flight
// at a time. Every output comes straight from a register.
//
// Handshake: a requester raises req with a stable addr and holds both
// until it sees a one-cycle gnt pulse. Dropping req before gnt withdraws
// the request. After gnt, req and addr are ignored for the read in
// flight, and a req that is still high counts as a new request. The read
// data arrives later as a one-cycle rvalid pulse. rdata holds its value
// until the next rvalid for that requester.
`timescale 1ns/1ps
module sram_ro_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int READ_LAT     = 1,
  parameter int FIXED_PRIO_B = 0
) (
  input  logic          mgmt_clk,
  input  logic          resetb,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          sram_csb1,
  output logic [AW:0]   sram_addr1,
  input  logic [DW-1:0] sram_dout1,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Counter reload: cycles still to wait after ISSUE before dout1 is valid.
  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          sel_b_q, sel_b_d;     // requester owning the read in flight
  logic          last_b_q, last_b_d;   // last granted requester was B
  logic          csb_q, csb_d;
  logic [AW:0]   addr_q, addr_d;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic          a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          win_b;

  // B wins when it is the only one asking, when B has fixed priority, or
  // when round-robin says A was served last.
  assign win_b = b_req & (~a_req | (FIXED_PRIO_B != 0) | ~last_b_q);

  // Next-state and registered-output logic for the read sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_b_d   = sel_b_q;
    last_b_d  = last_b_q;
    csb_d     = 1'b1;
    addr_d    = addr_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_rv_d    = 1'b0;
    b_rv_d    = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      // RESP arbitrates like IDLE so a waiting request goes straight to ISSUE.
      IDLE, RESP: begin
        if (a_req | b_req) begin
          state_d  = ISSUE;
          csb_d    = 1'b0;
          sel_b_d  = win_b;
          last_b_d = win_b;
          addr_d   = win_b ? {1'b1, b_addr} : {1'b0, a_addr};
          a_gnt_d  = ~win_b;
          b_gnt_d  = win_b;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          if (sel_b_q) begin
            b_rdata_d = sram_dout1;
            b_rv_d    = 1'b1;
          end else begin
            a_rdata_d = sram_dout1;
            a_rv_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any read in flight.
  always_ff @(posedge mgmt_clk) begin
    if (!resetb) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      sel_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      csb_q     <= 1'b1;
      addr_q    <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_rv_q    <= 1'b0;
      b_rv_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_b_q   <= sel_b_d;
      last_b_q  <= last_b_d;
      csb_q     <= csb_d;
      addr_q    <= addr_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_rv_q    <= a_rv_d;
      b_rv_q    <= b_rv_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_rvalid   = a_rv_q;
  assign b_rvalid   = b_rv_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign sram_csb1  = csb_q;
  assign sram_addr1 = addr_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_ro_arbiter.sv
// Testbench for sram_ro_arbiter: three configurations run side by side
// (round-robin READ_LAT=1, fixed-B READ_LAT=1, round-robin READ_LAT=3),
// each with its own SRAM macro model and a cycle-timing reference model.
`timescale 1ns/1ps
module tb_sram_ro_arbiter;

  logic clk;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int RL = (g == 2) ? 3 : 1;
    localparam int PB = (g == 1) ? 1 : 0;

    logic        rstb, a_req, b_req;
    logic [7:0]  a_addr, b_addr;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, csb, busy;
    logic [31:0] a_rdata, b_rdata, dout;
    logic [8:0]  addr1;
    logic [1:0]  dbg;
    logic [31:0] mem [512];

    sram_ro_arbiter #(.AW(8), .DW(32), .READ_LAT(RL), .FIXED_PRIO_B(PB)) u_dut (
      .mgmt_clk  (clk),
      .resetb    (rstb),
      .a_req     (a_req),
      .a_addr    (a_addr),
      .a_gnt     (a_gnt),
      .a_rvalid  (a_rvalid),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_addr    (b_addr),
      .b_gnt     (b_gnt),
      .b_rvalid  (b_rvalid),
      .b_rdata   (b_rdata),
      .sram_csb1 (csb),
      .sram_addr1(addr1),
      .sram_dout1(dout),
      .busy      (busy),
      .dbg_state (dbg)
    );

    // SRAM macro: a read sampled with csb1 low shows its word RL edges
    // later; otherwise the bus carries a junk pattern.
    logic       pv [RL];
    logic [8:0] pa [RL];
    always @(posedge clk) begin
      pv[0] <= ~csb;
      pa[0] <= addr1;
      for (int i = 1; i < RL; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
    assign dout = (pv[RL-1] === 1'b1) ? mem[pa[RL-1]] : 32'hBAD0F00D;

    // ---------------- reference model ----------------
    string       pfx;
    int          c;
    bit          chk_on;
    bit          e_ga [16];
    bit          e_gb [16];
    bit          e_cs [16];
    bit          e_ra [16];
    bit          e_rb [16];
    logic [31:0] exp_a_q [$];
    logic [31:0] exp_b_q [$];
    logic [31:0] m_ard, m_brd;
    logic [8:0]  m_addr;
    bit          m_last_b;
    int          next_arb, busy_end;

    task automatic clear_all();
      for (int i = 0; i < 16; i++) begin
        e_ga[i] = 0; e_gb[i] = 0; e_cs[i] = 0; e_ra[i] = 0; e_rb[i] = 0;
      end
    endtask

    // Apply the rules for the inputs present in cycle c.
    task automatic model_step();
      bit wb;
      int r;
      if (!rstb) begin
        clear_all();
        exp_a_q.delete();
        exp_b_q.delete();
        m_ard = 0; m_brd = 0; m_addr = 0;
        m_last_b = 1; next_arb = c + 1; busy_end = c; chk_on = 1;
      end else if (c >= next_arb && (a_req || b_req)) begin
        wb = b_req && (!a_req || PB != 0 || !m_last_b);
        m_last_b = wb;
        e_ga[(c+1)%16] = !wb;
        e_gb[(c+1)%16] = wb;
        e_cs[(c+1)%16] = 1;
        m_addr = wb ? {1'b1, b_addr} : {1'b0, a_addr};
        r = c + 2 + RL;
        if (wb) begin e_rb[r%16] = 1; exp_b_q.push_back(mem[m_addr]); end
        else    begin e_ra[r%16] = 1; exp_a_q.push_back(mem[m_addr]); end
        busy_end = r;
        next_arb = r;
      end
    endtask

    task automatic observe();
      int k;
      k = c % 16;
      if (chk_on) begin
        if (e_ra[k] && exp_a_q.size() > 0) m_ard = exp_a_q.pop_front();
        if (e_rb[k] && exp_b_q.size() > 0) m_brd = exp_b_q.pop_front();
        check_eq({pfx, "a_gnt"},    64'(a_gnt),    64'(e_ga[k]));
        check_eq({pfx, "b_gnt"},    64'(b_gnt),    64'(e_gb[k]));
        check_eq({pfx, "csb1"},     64'(csb),      64'(!e_cs[k]));
        check_eq({pfx, "addr1"},    64'(addr1),    64'(m_addr));
        check_eq({pfx, "a_rvalid"}, 64'(a_rvalid), 64'(e_ra[k]));
        check_eq({pfx, "b_rvalid"}, 64'(b_rvalid), 64'(e_rb[k]));
        check_eq({pfx, "a_rdata"},  64'(a_rdata),  64'(m_ard));
        check_eq({pfx, "b_rdata"},  64'(b_rdata),  64'(m_brd));
        check_eq({pfx, "busy"},     64'(busy),     64'(c <= busy_end));
      end
      e_ga[k] = 0; e_gb[k] = 0; e_cs[k] = 0; e_ra[k] = 0; e_rb[k] = 0;
    endtask

    // One clock: model the current inputs, advance, check the new cycle.
    task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      c++;
      observe();
    endtask

    // ---------------- driver ----------------
    task automatic pick(input logic req, input logic gnt, input logic [7:0] addr,
                        input int pr, input int prr, input int pd,
                        output logic nreq, output logic [7:0] naddr);
      nreq  = req;
      naddr = addr;
      if (req && gnt) begin
        nreq  = ($urandom_range(99) < prr);
        naddr = 8'($urandom);
      end else if (req) begin
        if ($urandom_range(99) < pd) nreq = 1'b0;
      end else if ($urandom_range(99) < pr) begin
        nreq  = 1'b1;
        naddr = 8'($urandom);
      end
    endtask

    task automatic wait_gnt(input bit is_b);
      int    n;
      string t;
      n = 0;
      do begin
        tick();
        n++;
      end while (((is_b ? b_gnt : a_gnt) !== 1'b1) && n < 30);
      if (is_b) t = "b_gnt_seen"; else t = "a_gnt_seen";
      check_eq({pfx, t}, 64'(is_b ? b_gnt : a_gnt), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
      int na, nb, ngr;
      pfx = $sformatf("cfg%0d ", g);
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[9'h005] = 32'hDEADBEEF;
      rstb = 1'b0; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
      c = 0; chk_on = 0; m_ard = 0; m_brd = 0; m_addr = 0; m_last_b = 1;
      next_arb = 0; busy_end = -1;
      clear_all();
      repeat (2) tick();
      rstb = 1'b1;

      // Single A read of the known word at 0x005.
      a_req = 1'b1; a_addr = 8'h05;
      wait_gnt(0);
      check_eq({pfx, "a_addr1_005"}, 64'(addr1), 64'h005);
      a_req = 1'b0;
      repeat (5) tick();
      check_eq({pfx, "a_rdata_dead"}, 64'(a_rdata), 64'hDEADBEEF);
      check_eq({pfx, "b_rdata_idle"}, 64'(b_rdata), 64'h0);

      // Single B read at the top of the macro.
      b_req = 1'b1; b_addr = 8'hFF;
      wait_gnt(1);
      check_eq({pfx, "b_addr1_1ff"}, 64'(addr1), 64'h1FF);
      b_req = 1'b0;
      repeat (5) tick();
      check_eq({pfx, "b_rdata_1ff"}, 64'(b_rdata), 64'(mem[9'h1FF]));

      // Both requesters held continuously.
      na = 0; nb = 0;
      a_req = 1'b1; b_req = 1'b1; a_addr = 8'($urandom); b_addr = 8'($urandom);
      repeat (18) begin
        pick(a_req, a_gnt, a_addr, 100, 100, 0, a_req, a_addr);
        pick(b_req, b_gnt, b_addr, 100, 100, 0, b_req, b_addr);
        tick();
        if (a_gnt) na++;
        if (b_gnt) nb++;
      end
      ngr = (18 - 1) / (RL + 2) + 1;
      check_eq({pfx, "held_a_grants"}, 64'(na), 64'((PB != 0) ? 0 : (ngr + 1) / 2));
      check_eq({pfx, "held_b_grants"}, 64'(nb), 64'((PB != 0) ? ngr : ngr / 2));
      if (a_gnt) a_addr = 8'($urandom);
      a_req = 1'b1; b_req = 1'b0;
      wait_gnt(0);
      a_req = 1'b0;
      repeat (6) tick();

      // Reset in the cycle after a grant abandons the read.
      a_req = 1'b1; a_addr = 8'($urandom);
      wait_gnt(0);
      a_req = 1'b0;
      tick();
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      check_eq({pfx, "rst_a_rdata"}, 64'(a_rdata), 64'h0);
      check_eq({pfx, "rst_csb1"},    64'(csb),     64'h1);
      check_eq({pfx, "rst_busy"},    64'(busy),    64'h0);
      repeat (RL + 3) tick();
      a_req = 1'b1; a_addr = 8'($urandom);
      wait_gnt(0);
      a_req = 1'b0;
      repeat (6) tick();

      // Random traffic with withdrawals and occasional resets.
      repeat (400) begin
        pick(a_req, a_gnt, a_addr, 30, 40, 5, a_req, a_addr);
        pick(b_req, b_gnt, b_addr, 30, 40, 5, b_req, b_addr);
        rstb = ($urandom_range(199) != 0);
        tick();
      end
      rstb = 1'b1; a_req = 1'b0; b_req = 1'b0;
      repeat (8) tick();
      n_done++;
    end
  end

  // ---------------- report ----------------
  initial begin
    wait (n_done == 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100us;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_ro_arbiter.md
Name: sram_ro_arbiter

Overview:
Arbitrates the SRAM read-only port (port 1 of the 32x512 OpenRAM macro) between two requesters: the management RO path (A) and the housekeeping/flash-boot RO path (B). Each requester uses a req/gnt handshake. The block sequences one read at a time: it drives csb1 and addr1, waits for the macro's read latency, then captures dout1 into a per-requester data register with a one-cycle valid pulse. A is mapped to the lower half of the macro (addr1[8]=0) and B to the upper half (addr1[8]=1).

Parameters:
AW, 8, requester address width; the SRAM address is AW+1 bits.
DW, 32, data width.
READ_LAT, 1, cycles from the csb1-low sampling edge to the edge where dout1 is valid to capture (1..3).
FIXED_PRIO_B, 0, 0 = round-robin; 1 = B always wins a tie.

Ports:
mgmt_clk  input  1  clock; all logic is on the rising edge.
resetb  input  1  synchronous active-low reset.
a_req  input  1  A read request; held with a_addr stable until a_gnt.
a_addr  input  AW  A word address.
a_gnt  output  1  one-cycle pulse; A's request is accepted.
a_rvalid  output  1  one-cycle pulse; a_rdata is updated.
a_rdata  output  DW  last data read for A.
b_req  input  1  B read request; same rules as A.
b_addr  input  AW  B word address.
b_gnt  output  1  one-cycle pulse; B's request is accepted.
b_rvalid  output  1  one-cycle pulse; b_rdata is updated.
b_rdata  output  DW  last data read for B.
sram_csb1  output  1  SRAM port-1 chip select, active low, registered.
sram_addr1  output  AW+1  SRAM port-1 address, registered.
sram_dout1  input  DW  SRAM port-1 read data.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (resetb low at an edge, including mid-transaction): state=IDLE, sram_csb1=1, sram_addr1=0, gnt/rvalid=0, a_rdata=b_rdata=0, last_grant=B (A wins the first tie). Any in-flight read is abandoned and produces no rvalid.
- FSM states are IDLE, ISSUE, WAIT and RESP. All outputs are registered.
- IDLE: if a_req|b_req, arbitrate and move to ISSUE. Register sram_csb1=0, sram_addr1={sel, addr_sel}, the gnt of the winner, and last_grant=winner. Otherwise stay in IDLE.
- Arbitration:
  - Exactly one req: that requester wins.
  - Both, FIXED_PRIO_B=1: B wins.
  - Both, FIXED_PRIO_B=0: the requester that is not last_grant wins.
- ISSUE (one cycle): gnt is high and csb1 is low; the macro samples at the end of this cycle. Next state is WAIT with counter=READ_LAT-1. Register csb1=1 and gnt=0.
- WAIT: when counter==0, capture sram_dout1 into the winner's rdata, pulse its rvalid, and go to RESP. Otherwise decrement the counter.
- RESP (one cycle): rvalid is high. It arbitrates exactly like IDLE, so a pending request goes directly to ISSUE; otherwise the next state is IDLE.
- Latency with READ_LAT=1: req first seen in cycle 0, gnt and csb1=0 in cycle 1, rvalid in cycle 3. Back-to-back period is READ_LAT+2 cycles.
- sram_addr1 holds its value outside ISSUE. sram_csb1 is low only in ISSUE.
- A req dropped before gnt is withdrawn and no read is issued. Req or addr changes after gnt do not affect the in-flight read.
- rdata holds its value until the next rvalid for that requester. A requester may re-request in the cycle after its gnt.
- gnt and rvalid are never high for both requesters in the same cycle.

Test Plan:
- Reset, then a_req=1, a_addr=8'h05, macro returning 32'hDEADBEEF for 9'h005 -> a_gnt and csb1=0 with addr1=9'h005 in cycle 1, a_rvalid in cycle 3, a_rdata=32'hDEADBEEF; b outputs stay 0.
- b_req=1, b_addr=8'hFF -> sram_addr1=9'h1FF; b_rdata equals the macro word at 9'h1FF.
- Both req held continuously, FIXED_PRIO_B=0 -> grants alternate A,B,A,B with gnt pulses 3 cycles apart; each rdata matches its own address.
- Both req held continuously, FIXED_PRIO_B=1 -> only B is granted; A is not served until b_req drops.
- READ_LAT=3, single A read -> rvalid in cycle 5; csb1 is low for exactly one cycle.
- resetb low in the cycle after gnt -> no rvalid occurs, csb1=1, rdata=0, and the FSM returns to IDLE. A new request after reset completes normally.
